// File: rtl/rect_plot_pkg.sv
// Shared encodings and screen defaults for the rectangle rasteriser.
package rect_plot_pkg;

  localparam logic [1:0] MODE_FILL    = 2'b00;
  localparam logic [1:0] MODE_OUTLINE = 2'b01;
  localparam logic [1:0] MODE_CLEAR   = 2'b10;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DRAW = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int unsigned DEF_SCREEN_W = 160;
  localparam int unsigned DEF_SCREEN_H = 120;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rect_plotter_raster_counter.sv
// Column-fastest raster walker over a latched w x h box; exposes the position
// that will be current after the next edge so the caller can register pixels.
module raster_counter #(
  parameter int unsigned DIM_W = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [DIM_W-1:0] w_i,
  input  logic [DIM_W-1:0] h_i,
  output logic [DIM_W-1:0] c_nxt_c,
  output logic [DIM_W-1:0] r_nxt_c,
  output logic             edge_c,
  output logic             last_c
);

  logic [DIM_W-1:0] c_q, c_d;
  logic [DIM_W-1:0] r_q, r_d;
  logic [DIM_W-1:0] wl_q, wl_d;
  logic [DIM_W-1:0] hl_q, hl_d;

  always_comb begin
    c_d  = c_q;
    r_d  = r_q;
    wl_d = wl_q;
    hl_d = hl_q;
    if (load_i) begin
      c_d  = '0;
      r_d  = '0;
      wl_d = w_i;
      hl_d = h_i;
    end else if (en_i) begin
      if (c_q == wl_q - DIM_W'(1)) begin
        c_d = '0;
        r_d = r_q + DIM_W'(1);
      end else begin
        c_d = c_q + DIM_W'(1);
      end
    end
  end

  // Border test is on the upcoming position, matching the registered pixel.
  always_comb begin
    c_nxt_c = c_d;
    r_nxt_c = r_d;
    edge_c  = (c_d == '0) || (c_d == wl_d - DIM_W'(1)) ||
              (r_d == '0) || (r_d == hl_d - DIM_W'(1));
    last_c  = (c_q == wl_q - DIM_W'(1)) && (r_q == hl_q - DIM_W'(1));
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      c_q  <= '0;
      r_q  <= '0;
      wl_q <= '0;
      hl_q <= '0;
    end else begin
      c_q  <= c_d;
      r_q  <= r_d;
      wl_q <= wl_d;
      hl_q <= hl_d;
    end
  end

endmodule

// File: rtl/rect_plotter.sv
// Rectangle rasteriser (fill / outline / clear) feeding the vga_adapter
// pixel-write port, one pixel per cycle with edge clipping.
module rect_plotter
  import rect_plot_pkg::*;
#(
  parameter int unsigned X_W      = 8,
  parameter int unsigned Y_W      = 7,
  parameter int unsigned COLOUR_W = 3,
  parameter int unsigned SCREEN_W = DEF_SCREEN_W,
  parameter int unsigned SCREEN_H = DEF_SCREEN_H,
  parameter int unsigned DIM_W    = 6
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start,
  input  logic [1:0]          mode,
  input  logic [X_W-1:0]      x0,
  input  logic [Y_W-1:0]      y0,
  input  logic [DIM_W-1:0]    w,
  input  logic [DIM_W-1:0]    h,
  input  logic [COLOUR_W-1:0] colour_in,
  output logic [X_W-1:0]      x,
  output logic [Y_W-1:0]      y,
  output logic [COLOUR_W-1:0] colour,
  output logic                plot,
  output logic                busy,
  output logic                done
);

  // Counter must hold both the operand widths and the full-screen extent.
  localparam int unsigned CNT_W = max_u(max_u(DIM_W, X_W), Y_W);
  localparam logic [CNT_W-1:0] SCR_W_CNT = CNT_W'(SCREEN_W);
  localparam logic [CNT_W-1:0] SCR_H_CNT = CNT_W'(SCREEN_H);
  localparam logic [X_W:0]     SCR_W_X   = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0]     SCR_H_Y   = (Y_W+1)'(SCREEN_H);

  logic [1:0]          state_q, state_d;
  logic [X_W-1:0]      x_q, x_d;
  logic [Y_W-1:0]      y_q, y_d;
  logic [COLOUR_W-1:0] colour_q, colour_d;
  logic                plot_q, plot_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [X_W-1:0]      x0_q, x0_d;
  logic [Y_W-1:0]      y0_q, y0_d;
  logic                outline_q, outline_d;

  logic                is_clear_c, is_outline_c;
  logic [CNT_W-1:0]    w_eff_c, h_eff_c;
  logic [X_W-1:0]      x0_eff_c, base_x_c;
  logic [Y_W-1:0]      y0_eff_c, base_y_c;
  logic                outl_c;
  logic [X_W:0]        px_c;
  logic [Y_W:0]        py_c;
  logic                pix_on_c;
  logic                load_c, en_c;
  logic [CNT_W-1:0]    c_nxt_c, r_nxt_c;
  logic                edge_c, last_c;

  raster_counter #(
    .DIM_W (CNT_W)
  ) u_raster (
    .clk     (clk),
    .resetn  (resetn),
    .load_i  (load_c),
    .en_i    (en_c),
    .w_i     (w_eff_c),
    .h_i     (h_eff_c),
    .c_nxt_c (c_nxt_c),
    .r_nxt_c (r_nxt_c),
    .edge_c  (edge_c),
    .last_c  (last_c)
  );

  // Operand decode; mode 11 falls through to fill.
  always_comb begin
    is_clear_c   = 1'b0;
    is_outline_c = 1'b0;
    case (mode)
      MODE_OUTLINE: is_outline_c = 1'b1;
      MODE_CLEAR:   is_clear_c   = 1'b1;
      MODE_FILL:    is_outline_c = 1'b0;
      default:      is_outline_c = 1'b0;
    endcase
    w_eff_c  = is_clear_c ? SCR_W_CNT : CNT_W'(w);
    h_eff_c  = is_clear_c ? SCR_H_CNT : CNT_W'(h);
    x0_eff_c = is_clear_c ? '0 : x0;
    y0_eff_c = is_clear_c ? '0 : y0;
  end

  // Upcoming pixel: live operands on acceptance, latched ones while drawing.
  always_comb begin
    base_x_c = (state_q == S_IDLE) ? x0_eff_c : x0_q;
    base_y_c = (state_q == S_IDLE) ? y0_eff_c : y0_q;
    outl_c   = (state_q == S_IDLE) ? is_outline_c : outline_q;
    px_c     = (X_W+1)'(base_x_c) + (X_W+1)'(c_nxt_c);
    py_c     = (Y_W+1)'(base_y_c) + (Y_W+1)'(r_nxt_c);
    pix_on_c = (px_c < SCR_W_X) && (py_c < SCR_H_Y) && (!outl_c || edge_c);
  end

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    colour_d  = colour_q;
    plot_d    = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    x0_d      = x0_q;
    y0_d      = y0_q;
    outline_d = outline_q;
    load_c    = 1'b0;
    en_c      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          x0_d      = x0_eff_c;
          y0_d      = y0_eff_c;
          outline_d = is_outline_c;
          if ((w_eff_c == '0) || (h_eff_c == '0)) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d  = S_DRAW;
            load_c   = 1'b1;
            busy_d   = 1'b1;
            colour_d = colour_in;
            x_d      = X_W'(px_c);
            y_d      = Y_W'(py_c);
            plot_d   = pix_on_c;
          end
        end
      end
      S_DRAW: begin
        if (last_c) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          en_c   = 1'b1;
          busy_d = 1'b1;
          x_d    = X_W'(px_c);
          y_d    = Y_W'(py_c);
          plot_d = pix_on_c;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      x_q       <= '0;
      y_q       <= '0;
      colour_q  <= '0;
      plot_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      x0_q      <= '0;
      y0_q      <= '0;
      outline_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      colour_q  <= colour_d;
      plot_q    <= plot_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      x0_q      <= x0_d;
      y0_q      <= y0_d;
      outline_q <= outline_d;
    end
  end

  assign x      = x_q;
  assign y      = y_q;
  assign colour = colour_q;
  assign plot   = plot_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_rect_plotter.sv
// Self-checking bench for rect_plotter: directed table, reset corner case and
// random rectangles against an arithmetic pixel model.
module tb_rect_plotter;

  logic       clk = 1'b0;
  logic       resetn;
  logic       start;
  logic [1:0] mode;
  logic [7:0] x0;
  logic [6:0] y0;
  logic [5:0] w;
  logic [5:0] h;
  logic [2:0] colour_in;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       busy;
  logic       done;

  int n_vec = 0;
  int n_err = 0;
  int last_x = 0;
  int last_y = 0;
  int last_col = 0;

  typedef struct {
    logic [1:0] m;
    int         x0;
    int         y0;
    int         w;
    int         h;
    logic [2:0] col;
    int         plots;
    bit         noisy;
  } vec_t;

  vec_t tbl[11];

  rect_plotter dut (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .mode      (mode),
    .x0        (x0),
    .y0        (y0),
    .w         (w),
    .h         (h),
    .colour_in (colour_in),
    .x         (x),
    .y         (y),
    .colour    (colour),
    .plot      (plot),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Pixel idx of a rectangle, from the raster-order definition.
  function automatic void model(input logic [1:0] m, input int ix0, input int iy0,
                                input int iw, input int ih, input int idx,
                                output int ex, output int ey, output bit ep);
    int ww, hh, bx, by, c, r;
    bit outl;
    ww = iw; hh = ih; bx = ix0; by = iy0;
    outl = (m == 2'b01);
    if (m == 2'b10) begin
      ww = 160; hh = 120; bx = 0; by = 0;
    end
    c  = idx % ww;
    r  = idx / ww;
    ex = (bx + c) % 256;
    ey = (by + r) % 128;
    ep = (bx + c < 160) && (by + r < 120) &&
         (!outl || c == 0 || c == ww - 1 || r == 0 || r == hh - 1);
  endfunction

  task automatic run_rect(input logic [1:0] m, input int ix0, input int iy0,
                          input int iw, input int ih, input logic [2:0] col,
                          input int exp_plots, input bit noisy);
    int n, ex, ey, plots;
    bit ep;
    n = (m == 2'b10) ? 160 * 120 : iw * ih;
    @(negedge clk);
    start = 1'b1; mode = m; x0 = 8'(ix0); y0 = 7'(iy0);
    w = 6'(iw); h = 6'(ih); colour_in = col;
    @(negedge clk);
    start = 1'b0;
    plots = 0;
    for (int i = 0; i < n; i++) begin
      model(m, ix0, iy0, iw, ih, i, ex, ey, ep);
      check("busy_high", int'(busy), 1);
      check("done_low", int'(done), 0);
      check("x", int'(x), ex);
      check("y", int'(y), ey);
      check("plot", int'(plot), int'(ep));
      check("colour", int'(colour), int'(col));
      if (plot) plots++;
      last_x = ex; last_y = ey; last_col = int'(col);
      if (noisy) begin
        start = 1'($urandom); mode = 2'($urandom); x0 = 8'($urandom);
        y0 = 7'($urandom); w = 6'($urandom); h = 6'($urandom);
        colour_in = 3'($urandom);
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("done_pulse", int'(done), 1);
    check("busy_in_done", int'(busy), 0);
    check("plot_in_done", int'(plot), 0);
    check("x_hold", int'(x), last_x);
    check("y_hold", int'(y), last_y);
    check("colour_hold", int'(colour), last_col);
    if (exp_plots >= 0) check("plot_count", plots, exp_plots);
    @(negedge clk);
    check("done_clear", int'(done), 0);
    check("busy_idle", int'(busy), 0);
    check("plot_idle", int'(plot), 0);
  endtask

  initial begin
    tbl[0]  = '{2'b00, 10, 20, 4, 4, 3'b100, 16, 1'b0};
    tbl[1]  = '{2'b01, 0, 0, 5, 3, 3'b010, 12, 1'b0};
    tbl[2]  = '{2'b00, 156, 116, 8, 8, 3'b111, 16, 1'b1};
    tbl[3]  = '{2'b10, 77, 33, 9, 9, 3'b000, 19200, 1'b1};
    tbl[4]  = '{2'b00, 5, 5, 0, 7, 3'b101, 0, 1'b0};
    tbl[5]  = '{2'b01, 3, 3, 1, 5, 3'b011, 5, 1'b0};
    tbl[6]  = '{2'b11, 50, 50, 3, 2, 3'b110, 6, 1'b0};
    tbl[7]  = '{2'b00, 200, 10, 5, 2, 3'b001, 0, 1'b0};
    tbl[8]  = '{2'b00, 30, 118, 2, 4, 3'b010, 4, 1'b0};
    tbl[9]  = '{2'b01, 158, 0, 3, 3, 3'b100, 5, 1'b0};
    tbl[10] = '{2'b01, 0, 0, 63, 63, 3'b111, 248, 1'b0};

    resetn = 1'b0; start = 1'b0; mode = '0; x0 = '0; y0 = '0;
    w = '0; h = '0; colour_in = '0;
    #12;
    check("rst_x", int'(x), 0);
    check("rst_y", int'(y), 0);
    check("rst_colour", int'(colour), 0);
    check("rst_plot", int'(plot), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    @(negedge clk);
    resetn = 1'b1;

    for (int k = 0; k < 11; k++)
      run_rect(tbl[k].m, tbl[k].x0, tbl[k].y0, tbl[k].w, tbl[k].h,
               tbl[k].col, tbl[k].plots, tbl[k].noisy);

    // Reset mid-draw, then a clean redraw from pixel 0.
    @(negedge clk);
    start = 1'b1; mode = 2'b00; x0 = 8'd10; y0 = 7'd20; w = 6'd4; h = 6'd4;
    colour_in = 3'b101;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("pre_rst_busy", int'(busy), 1);
    check("pre_rst_x", int'(x), 11);
    #2 resetn = 1'b0;
    #1;
    check("arst_plot", int'(plot), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_x", int'(x), 0);
    check("arst_y", int'(y), 0);
    check("arst_colour", int'(colour), 0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check("post_rst_plot", int'(plot), 0);
    check("post_rst_busy", int'(busy), 0);
    check("post_rst_done", int'(done), 0);
    check("post_rst_x", int'(x), 0);
    last_x = 0; last_y = 0; last_col = 0;
    run_rect(2'b00, 10, 20, 4, 4, 3'b101, 16, 1'b0);

    // Random rectangles; clear mode stays in the directed set to bound runtime.
    for (int k = 0; k < 30; k++) begin
      logic [1:0] rm;
      rm = 2'($urandom);
      if (rm == 2'b10) rm = 2'b01;
      run_rect(rm, int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
               int'($urandom_range(0, 20)), int'($urandom_range(0, 20)),
               3'($urandom), -1, 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
